// File: rtl/mem_responder.sv
// Multicycle word memory responder: one request at a time, fixed LATENCY, one-cycle ready pulse.
// Optional error flag (misaligned / read+write collision) enabled by defining MEM_ERR_EN.
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_q, dout_d;
  logic               mem_we;
  logic [31:0]        mem_q [DEPTH];
  logic               accept;

  // Byte-offset and above-index address bits play no part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  assign accept = (state_q == IDLE) && (mem_read || mem_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = mem_write;
          idx_d   = addr[IDX_W+1:2];
          wdata_d = din;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (wr_q) mem_we = 1'b1;
          else      dout_d = mem_q[idx_q];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  // Storage has no reset; the commit only fires in BUSY, which reset clears asynchronously.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign dout  = dout_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);

`ifdef MEM_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept)                 err_d = (addr[1:0] != 2'b00) || (mem_read && mem_write);
    else if (state_q == DONE)   err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// against an associative-array memory model; LATENCY=4 and LATENCY=1 instances.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
`ifdef MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] din_s   [2];
  logic [31:0] dout_s  [2];
  logic        ready_s [2];
  logic        busy_s  [2];
  logic        err_s   [2];

  int unsigned lat [2];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] model [int unsigned];
  logic [31:0] last_dout [2];
  int unsigned wq [$];

  mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u0 (
    .clk(clk), .reset(reset), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .addr(addr_s[0]), .din(din_s[0]), .dout(dout_s[0]),
    .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .addr(addr_s[1]), .din(din_s[1]), .dout(dout_s[1]),
    .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance d, starting from a negedge with the block idle.
  task automatic req(input int d, input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] dv, input bit tog, input string tag);
    int unsigned key;
    int          n;
    logic [31:0] exp_dout;
    logic        exp_err;
    key = int'(d) * DEPTH + ((a >> 2) % DEPTH);
    wr_s[d] = wr; rd_s[d] = rd; addr_s[d] = a; din_s[d] = dv;
    @(negedge clk);
    chk({tag, "_busy_rise"}, 32'(busy_s[d]), 32'd1);
    n = 0;
    while (!ready_s[d] && n < 40) begin
      if (tog) begin
        wr_s[d] = 1'($urandom); rd_s[d] = 1'($urandom); addr_s[d] = $urandom; din_s[d] = $urandom;
      end else begin
        wr_s[d] = 1'b0; rd_s[d] = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat[d]));
    if (wr) begin
      model[key] = dv;
      if (d == 0) wq.push_back(key);
    end else begin
      last_dout[d] = model.exists(key) ? model[key] : 32'hx;
    end
    exp_dout = last_dout[d];
    exp_err  = ERR_EN && ((a[1:0] != 2'b00) || (wr && rd));
    chk({tag, "_dout"}, dout_s[d], exp_dout);
    chk({tag, "_err"}, 32'(err_s[d]), 32'(exp_err));
    wr_s[d] = 1'b0; rd_s[d] = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, ready_s[d], busy_s[d]}, 32'd0);
    chk({tag, "_err_clr"}, 32'(err_s[d]), 32'd0);
    chk({tag, "_dout_hold"}, dout_s[d], exp_dout);
  endtask

  initial begin
    int          cnt;
    int          first;
    int          second;
    int unsigned idx;
    int unsigned op;
    logic [31:0] a;
    logic [31:0] dv;

    lat[0] = 4; lat[1] = 1;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; din_s[i] = '0; last_dout[i] = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", {29'd0, ready_s[i], busy_s[i], err_s[i]}, 32'd0);
      chk("reset_dout", dout_s[i], 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);

    req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "wr_10");
    req(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "rd_10");

    req(0, 1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, 1'b0, "wr_wrap");
    req(0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, "rd_wrap");

    req(0, 1'b1, 1'b1, 32'h8, 32'h55, 1'b0, "both_8");
    req(0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, "rd_8");

    req(0, 1'b1, 1'b0, 32'h4, 32'h11112222, 1'b0, "wr_4");
    req(0, 1'b0, 1'b1, 32'h6, 32'h0, 1'b0, "rd_misaligned");

    req(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "rd_toggle");
    req(0, 1'b1, 1'b0, 32'h24, 32'h77778888, 1'b1, "wr_toggle");
    @(negedge clk);
    chk("no_extra_accept", {30'd0, ready_s[0], busy_s[0]}, 32'd0);

    // Reset in the middle of a write: old contents must survive.
    req(0, 1'b1, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, "wr_20");
    wr_s[0] = 1'b1; addr_s[0] = 32'h20; din_s[0] = 32'h12345678;
    @(posedge clk);
    #1 wr_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("midwr_busy", 32'(busy_s[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk("midwr_async_clear", {30'd0, ready_s[0], busy_s[0]}, 32'd0);
    chk("midwr_dout_clear", dout_s[0], 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_dout[0] = '0; last_dout[1] = '0;
    @(negedge clk);
    req(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, "rd_after_reset");

    // LATENCY=1 instance: held read request is re-accepted every 3 edges.
    req(1, 1'b1, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, "l1_wr_0");
    req(1, 1'b1, 1'b0, 32'h4, 32'hCAFE0002, 1'b0, "l1_wr_4");
    rd_s[1] = 1'b1; addr_s[1] = 32'h0;
    cnt = 0; first = -1; second = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready_s[1]) begin
        cnt++;
        if (cnt == 1) begin
          first = c;
          chk("b2b_dout0", dout_s[1], 32'hCAFE0001);
          addr_s[1] = 32'h4;
        end else if (cnt == 2) begin
          second = c;
          chk("b2b_dout4", dout_s[1], 32'hCAFE0002);
          rd_s[1] = 1'b0;
        end
      end
    end
    last_dout[1] = 32'hCAFE0002;
    chk("b2b_pulses", 32'(cnt), 32'd2);
    chk("b2b_first", 32'(first), 32'd1);
    chk("b2b_spacing", 32'(second - first), 32'd3);
    chk("b2b_idle", {30'd0, ready_s[1], busy_s[1]}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      if (op == 1) idx = wq[$urandom_range(0, wq.size() - 1)] % DEPTH;
      else         idx = $urandom_range(0, 31);
      a  = ($urandom & 32'hFFFF_F000) | (idx << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      dv = $urandom;
      case (op)
        0:       req(0, 1'b1, 1'b0, a, dv, 1'($urandom), "rand_wr");
        1:       req(0, 1'b0, 1'b1, a, dv, 1'($urandom), "rand_rd");
        default: req(0, 1'b1, 1'b1, a, dv, 1'($urandom), "rand_both");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
